// File: rtl/mem_ram_rom_pkg.sv
// Shared state encoding and helpers for the RAM/ROM controller.
package mem_ram_rom_pkg;

   typedef enum logic [1:0] {CLEAR, IDLE, RESP} state_t;

   // Constant ROM image: each word holds its own index, truncated to data_w bits.
   function automatic logic [31:0] rom_word(input int unsigned i, input int unsigned data_w);
      logic [63:0] w_mask;
      w_mask = (64'd1 << data_w) - 64'd1;
      return 32'(64'(i) & w_mask);
   endfunction

   // Even parity: the bit that makes data plus parity hold an even count of ones.
   function automatic logic parity(input logic [31:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/mem_ram_bank.sv
// Single-port synchronous RAM bank with registered read; contents are not reset.
module mem_ram_bank #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_en,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [WIDTH-1:0]  i_wdata,
   output logic [WIDTH-1:0]  o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Read data only moves on an enabled read, so it stays stable while a response is held.
   always_ff @(posedge clk) begin
      if (i_en) begin
         if (i_we) r_mem[i_addr] <= i_wdata;
         else      o_rdata       <= r_mem[i_addr];
      end
   end

endmodule

// File: rtl/mem_ram_rom_ctrl.sv
// ROM + RAM bank behind a valid/ready request/response pair, with a RAM clear sweep after reset.
// Optional RAM parity storage and checking is enabled by defining MEM_PARITY_EN.
module mem_ram_rom_ctrl
   import mem_ram_rom_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH = 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
`ifdef MEM_PARITY_EN
   input  logic              inject_perr,
`endif
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic              req_cs,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_err,
   output logic              busy
);

`ifdef MEM_PARITY_EN
   localparam int RAM_W = DATA_W + 1;
`else
   localparam int RAM_W = DATA_W;
`endif
   localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

   state_t            r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_req_ready, r_resp_valid, r_resp_err, r_busy, r_rd_ram;
   logic [DATA_W-1:0] r_resp_data;

   logic              w_accept, w_in_range, w_ram_en, w_ram_we, w_perr;
   logic [ADDR_W-1:0] w_ram_addr;
   logic [DATA_W-1:0] w_ram_data, w_rom_data;
   logic [RAM_W-1:0]  w_ram_wdata, w_ram_rdata;

   assign w_accept   = req_valid & r_req_ready;
   assign w_in_range = {1'b0, req_addr} < LP_DEPTH;
   assign w_rom_data = DATA_W'(rom_word(32'(req_addr), DATA_W));

   always_comb begin
      w_ram_en   = 1'b0;
      w_ram_we   = 1'b0;
      w_ram_addr = req_addr;
      w_ram_data = req_wdata;
      if (r_state == CLEAR) begin
         w_ram_en   = 1'b1;
         w_ram_we   = 1'b1;
         w_ram_addr = r_cnt;
         w_ram_data = '0;
      end else if (w_accept && !req_cs && w_in_range) begin
         w_ram_en = 1'b1;
         w_ram_we = req_we;
      end
   end

`ifdef MEM_PARITY_EN
   assign w_ram_wdata = {parity(32'(w_ram_data)) ^ inject_perr, w_ram_data};
   assign w_perr      = w_ram_rdata[DATA_W] != parity(32'(w_ram_rdata[DATA_W-1:0]));
`else
   assign w_ram_wdata = w_ram_data;
   assign w_perr      = 1'b0;
`endif

   mem_ram_bank #(.WIDTH(RAM_W), .DEPTH(DEPTH)) u_ram (
      .clk     (clk),
      .i_en    (w_ram_en),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_addr),
      .i_wdata (w_ram_wdata),
      .o_rdata (w_ram_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= CLEAR;
         r_cnt        <= '0;
         r_req_ready  <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_data  <= '0;
         r_resp_err   <= 1'b0;
         r_busy       <= 1'b1;
         r_rd_ram     <= 1'b0;
      end else begin
         case (r_state)
            CLEAR: begin
               r_cnt <= r_cnt + ADDR_W'(1);
               if (r_cnt == LP_LAST) begin
                  r_cnt       <= '0;
                  r_state     <= IDLE;
                  r_busy      <= 1'b0;
                  r_req_ready <= 1'b1;
               end
            end
            IDLE: if (w_accept) begin
               r_state      <= RESP;
               r_req_ready  <= 1'b0;
               r_resp_valid <= 1'b1;
               r_resp_data  <= '0;
               r_resp_err   <= 1'b0;
               r_rd_ram     <= 1'b0;
               if (!w_in_range) begin
                  r_resp_err <= 1'b1;
               end else if (req_cs) begin
                  r_resp_data <= w_rom_data;
                  r_resp_err  <= req_we;
               end else if (req_we) begin
                  r_resp_data <= req_wdata;
               end else begin
                  r_rd_ram <= 1'b1;
               end
            end
            RESP: if (resp_ready) begin
               r_state      <= IDLE;
               r_resp_valid <= 1'b0;
               r_req_ready  <= 1'b1;
            end
            default: r_state <= CLEAR;
         endcase
      end
   end

   // RAM reads come straight from the bank's read register, so resp_* remain register-driven.
   assign resp_data  = r_rd_ram ? w_ram_rdata[DATA_W-1:0] : r_resp_data;
   assign resp_err   = r_resp_err | (r_rd_ram & w_perr);
   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign busy       = r_busy;

endmodule

// File: tb/tb_mem_ram_rom_ctrl.sv
// Directed bench for mem_ram_rom_ctrl: an 8-deep instance plus a 6-deep one for range errors.
module tb_mem_ram_rom_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   always #5 clk = ~clk;

   logic       req_valid = 1'b0, req_we = 1'b0, req_cs = 1'b0, resp_ready = 1'b0;
   logic [2:0] req_addr = '0;
   logic [7:0] req_wdata = '0;
   logic       req_ready, resp_valid, resp_err, busy;
   logic [7:0] resp_data;
`ifdef MEM_PARITY_EN
   logic       inject_perr = 1'b0;
   logic       inject_perr6 = 1'b0;
`endif

   logic       req_valid6 = 1'b0, resp_ready6 = 1'b0;
   logic [2:0] req_addr6 = '0;
   logic       req_ready6, resp_valid6, resp_err6, busy6;
   logic [7:0] resp_data6;

   mem_ram_rom_ctrl #(.DATA_W(8), .DEPTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
`ifdef MEM_PARITY_EN
      .inject_perr(inject_perr),
`endif
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_cs     (req_cs),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .busy       (busy)
   );

   mem_ram_rom_ctrl #(.DATA_W(8), .DEPTH(6)) dut6 (
      .clk        (clk),
      .rst        (rst),
`ifdef MEM_PARITY_EN
      .inject_perr(inject_perr6),
`endif
      .req_valid  (req_valid6),
      .req_ready  (req_ready6),
      .req_we     (1'b0),
      .req_cs     (1'b0),
      .req_addr   (req_addr6),
      .req_wdata  (8'h00),
      .resp_valid (resp_valid6),
      .resp_ready (resp_ready6),
      .resp_data  (resp_data6),
      .resp_err   (resp_err6),
      .busy       (busy6)
   );

   int n_checks = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Called on the negedge where rst is released; counts cycles until the block is ready.
   task automatic sweep_len(input string tag);
      int n = 0;
      while ((busy || !req_ready) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(n), 32'd8);
   endtask

   task automatic xact(input string tag, input logic we, input logic cs, input logic [2:0] addr,
                       input logic [7:0] wdata, input int hold,
                       output logic [7:0] data, output logic err);
      int n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      req_valid = 1'b1; req_we = we; req_cs = cs; req_addr = addr; req_wdata = wdata;
      resp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      check({tag, "_vld"}, 32'({resp_valid, req_ready}), 32'b10);
      data = resp_data;
      err  = resp_err;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold"}, 32'({resp_valid, req_ready, resp_err, resp_data}), 32'({2'b10, err, data}));
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check({tag, "_done"}, 32'({resp_valid, req_ready}), 32'b01);
      $display("xact %s we=%0d cs=%0d addr=%0d wdata=%02h -> data=%02h err=%0d", tag, we, cs, addr, wdata, data, err);
   endtask

   logic [7:0] d;
   logic       e;
   logic [2:0] d6_addr [3] = '{3'd7, 3'd6, 3'd5};
   logic       d6_err  [3] = '{1'b1, 1'b1, 1'b0};

   initial begin
      repeat (3) @(negedge clk);
      check("rst_state", 32'({busy, req_ready, resp_valid, resp_err, resp_data}), 32'({4'b1000, 8'h00}));
      rst = 1'b0;
      sweep_len("sweep_first");

      xact("rd_ram5", 1'b0, 1'b0, 3'd5, 8'h00, 0, d, e);
      check("rd_ram5", 32'({e, d}), 32'({1'b0, 8'h00}));
      xact("wr_ram3", 1'b1, 1'b0, 3'd3, 8'hA5, 0, d, e);
      check("wr_ram3", 32'({e, d}), 32'({1'b0, 8'hA5}));
      xact("rd_ram3", 1'b0, 1'b0, 3'd3, 8'h00, 4, d, e);
      check("rd_ram3", 32'({e, d}), 32'({1'b0, 8'hA5}));
      xact("rd_rom6", 1'b0, 1'b1, 3'd6, 8'h00, 0, d, e);
      check("rd_rom6", 32'({e, d}), 32'({1'b0, 8'h06}));
      xact("wr_rom6", 1'b1, 1'b1, 3'd6, 8'hFF, 1, d, e);
      check("wr_rom6", 32'({e, d}), 32'({1'b1, 8'h06}));
      xact("rerd_rom6", 1'b0, 1'b1, 3'd6, 8'h00, 0, d, e);
      check("rerd_rom6", 32'({e, d}), 32'({1'b0, 8'h06}));
      xact("rd_rom7", 1'b0, 1'b1, 3'd7, 8'h00, 0, d, e);
      check("rd_rom7", 32'({e, d}), 32'({1'b0, 8'h07}));
      xact("wr_ram7", 1'b1, 1'b0, 3'd7, 8'h5A, 0, d, e);
      xact("wr_ram0", 1'b1, 1'b0, 3'd0, 8'hFF, 0, d, e);
      xact("rd_ram7", 1'b0, 1'b0, 3'd7, 8'h00, 0, d, e);
      check("rd_ram7", 32'({e, d}), 32'({1'b0, 8'h5A}));
      xact("rd_ram0", 1'b0, 1'b0, 3'd0, 8'h00, 0, d, e);
      check("rd_ram0", 32'({e, d}), 32'({1'b0, 8'hFF}));
      xact("rd_ram3b", 1'b0, 1'b0, 3'd3, 8'h00, 0, d, e);
      check("rd_ram3b", 32'({e, d}), 32'({1'b0, 8'hA5}));

      for (int i = 0; i < 3; i++) begin
         req_valid6 = 1'b1; req_addr6 = d6_addr[i];
         @(negedge clk);
         req_valid6 = 1'b0;
         check("d6_rd", 32'({resp_valid6, resp_err6, resp_data6}), 32'({1'b1, d6_err[i], 8'h00}));
         $display("xact d6 addr=%0d -> data=%02h err=%0d", d6_addr[i], resp_data6, resp_err6);
         resp_ready6 = 1'b1;
         @(negedge clk);
         resp_ready6 = 1'b0;
      end

`ifdef MEM_PARITY_EN
      inject_perr = 1'b1;
      xact("wr_perr", 1'b1, 1'b0, 3'd2, 8'h3C, 0, d, e);
      inject_perr = 1'b0;
      xact("rd_perr", 1'b0, 1'b0, 3'd2, 8'h00, 0, d, e);
      check("rd_perr", 32'({e, d}), 32'({1'b1, 8'h3C}));
      xact("wr_clean", 1'b1, 1'b0, 3'd2, 8'h3C, 0, d, e);
      xact("rd_clean", 1'b0, 1'b0, 3'd2, 8'h00, 0, d, e);
      check("rd_clean", 32'({e, d}), 32'({1'b0, 8'h3C}));
`endif

      // Reset while a ROM-write error response is pending.
      req_valid = 1'b1; req_we = 1'b1; req_cs = 1'b1; req_addr = 3'd6; req_wdata = 8'hFF;
      @(negedge clk);
      req_valid = 1'b0;
      check("pre_rst_resp", 32'({resp_valid, resp_err, resp_data}), 32'({2'b11, 8'h06}));
      rst = 1'b1;
      #1;
      check("rst_in_resp", 32'({busy, req_ready, resp_valid, resp_err, resp_data}), 32'({4'b1000, 8'h00}));
      @(negedge clk);
      rst = 1'b0;
      sweep_len("sweep_after_resp");
      xact("rd_ram3_cleared", 1'b0, 1'b0, 3'd3, 8'h00, 0, d, e);
      check("rd_ram3_cleared", 32'({e, d}), 32'({1'b0, 8'h00}));

      // Reset pulsed when the sweep counter has reached 4.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid_sweep", 32'({busy, req_ready, resp_valid}), 32'b100);
      @(negedge clk);
      rst = 1'b0;
      sweep_len("sweep_restart");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule
